ahb2apb_bridge_mp: RTL and testbench

Parametrised AHB-Lite to APB4 bridge. It is the successor of the fixed 3-slave bridge, generalised in data width and slave count, with an address-decoded one-hot PSEL. Compared with that bridge it adds:
- PREADY wait states
- PSLVERR-to-HRESP error mapping
- decode-error response
- byte strobes (PSTRB)

It sits between the system AHB fabric and the APB peripheral cluster (interrupt controller, timers, remap/pause, and others).

---
 rtl/ahb2apb_bridge_mp.sv | 117 +++++++++++
 tb/tb_ahb2apb_bridge_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge_mp.sv
// ahb2apb_bridge_mp: AHB-Lite to APB4 bridge with one-hot decoded PSEL, wait states, PSTRB and error mapping.
// Optional APB_TIMEOUT_EN aborts a stalled ACCESS into an AHB ERROR after TIMEOUT_CYCLES cycles.
module ahb2apb_bridge_mp #(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter int                NUM_SLAVES      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = 32'h8000_0000,
    parameter int                SLAVE_SIZE_LOG2 = 26,
    parameter int                TIMEOUT_CYCLES  = 256
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [ADDR_W-1:0]            HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [DATA_W-1:0]            HWDATA,
    input  logic                         HREADY,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    output logic [DATA_W-1:0]            HRDATA,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);
    localparam int BW    = DATA_W / 8;
    localparam int OFF_W = $clog2(BW);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {IDLE, WLAT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t              r_state, w_next, w_start;
    logic [IDX_W-1:0]    r_idx;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [BW-1:0]       r_pstrb;
    logic [ADDR_W-1:0]   w_off, w_slot;
    logic [BW-1:0]       w_nmask, w_strb;
    logic                w_hit, w_rdy, w_err, w_done, w_accept, w_apb, w_tout, w_unused;

    assign w_off    = HADDR - BASE_ADDR;
    assign w_slot   = w_off >> SLAVE_SIZE_LOG2;
    assign w_hit    = (HADDR >= BASE_ADDR) && (w_slot < ADDR_W'(NUM_SLAVES));
    // sizes at or above the bus width light every lane
    assign w_nmask  = (HSIZE >= 3'(OFF_W)) ? '1 : BW'((32'd1 << (32'd1 << HSIZE)) - 32'd1);
    assign w_strb   = w_nmask << HADDR[OFF_W-1:0];
    assign w_rdy    = PREADY[r_idx];
    assign w_err    = PSLVERR[r_idx];
    assign w_done   = (r_state == ACCESS) && w_rdy && !w_err;
    assign w_accept = HREADY && HTRANS[1] && (r_state == IDLE || r_state == ERR2 || w_done);
    assign w_start  = w_hit ? (HWRITE ? WLAT : SETUP) : ERR1;
    assign w_apb    = (r_state == SETUP) || (r_state == ACCESS);

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tcnt;
    always_ff @(posedge HCLK)
        r_tcnt <= (HRESET || r_state != ACCESS) ? '0 : r_tcnt + 1'b1;
    assign w_tout   = (r_state == ACCESS) && !w_rdy && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_unused = &{1'b0, HTRANS[0]};
`else
    assign w_tout   = 1'b0;
    assign w_unused = &{1'b0, HTRANS[0], TIMEOUT_CYCLES[0]};
`endif

    always_ff @(posedge HCLK)
        r_state <= HRESET ? IDLE : w_next;

    always_comb begin
        w_next    = r_state;
        HREADYOUT = (r_state == IDLE) || (r_state == ERR2) || w_done;
        HRESP     = (r_state == ERR1) || (r_state == ERR2) || ((r_state == ACCESS) && w_rdy && w_err);
        case (r_state)
            IDLE, ERR2: w_next = w_accept ? w_start : IDLE;
            WLAT:       w_next = SETUP;
            SETUP:      w_next = ACCESS;
            ACCESS:     w_next = w_tout ? ERR1 : !w_rdy ? ACCESS : w_err ? ERR1 : w_accept ? w_start : IDLE;
            ERR1:       w_next = ERR2;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_idx    <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else begin
            if (w_accept && w_hit) begin
                r_idx    <= w_slot[IDX_W-1:0];
                r_paddr  <= HADDR;
                r_pwrite <= HWRITE;
                r_pstrb  <= HWRITE ? w_strb : '0;
            end
            if (r_state == WLAT)
                r_pwdata <= HWDATA;
        end
    end

    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PSTRB   = r_pstrb;
    assign PSEL    = w_apb ? NUM_SLAVES'(1) << r_idx : '0;
    assign PENABLE = (r_state == ACCESS);
    assign PWRITE  = w_apb && r_pwrite;
    assign HRDATA  = ((r_state == ACCESS) && !r_pwrite) ? PRDATA[r_idx*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// tb_ahb2apb_bridge_mp: scoreboard bench; AHB completions and APB phases are checked against queued expectations.
module tb_ahb2apb_bridge_mp;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int TOUT = 8;

    logic         HCLK = 0, HRESET = 1;
    logic [31:0]  HADDR = 0, HWDATA = 0;
    logic [1:0]   HTRANS = 0;
    logic         HWRITE = 0;
    logic [2:0]   HSIZE = 0;
    logic         HREADY, HREADYOUT, HRESP, PENABLE, PWRITE;
    logic [31:0]  HRDATA, PADDR, PWDATA;
    logic [3:0]   PSEL, PSTRB, PREADY;
    logic [3:0]   PSLVERR = 0;
    logic [127:0] PRDATA = 0;

    int   wait_n = 0, acc_cnt = 0, checks = 0, errors = 0, wcnt = 0;
    logic dphase = 0, aph = 0, drop_ok = 0;

    typedef struct {logic [31:0] rdata; logic resp; int waits;} sb_t;
    typedef struct {logic [31:0] addr; logic [3:0] sel; logic wr; logic [31:0] wdata; logic [3:0] strb;} apb_t;
    sb_t  sbq[$];
    apb_t apbq[$];

    ahb2apb_bridge_mp #(.TIMEOUT_CYCLES(TOUT)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;
    assign PREADY = (acc_cnt >= wait_n) ? 4'hF : 4'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] strb_f(input logic [31:0] a, input logic [2:0] sz, input logic w);
        logic [3:0] m;
        m = (sz >= 2) ? 4'hF : (sz == 1) ? 4'b0011 : 4'b0001;
        return w ? m << a[1:0] : 4'h0;
    endfunction

    always @(posedge HCLK) begin
        acc_cnt <= (PENABLE && !(|(PSEL & PREADY))) ? acc_cnt + 1 : 0;
        dphase  <= HRESET ? 1'b0 : HREADYOUT ? HTRANS[1] : dphase;
    end

    always @(negedge HCLK) begin : sb_mon
        sb_t e;
        if (!dphase) wcnt = 0;
        else if (!HREADYOUT) wcnt++;
        else if (sbq.size() == 0) check("sb_extra", 64'(sbq.size()), 1);
        else begin
            e = sbq.pop_front();
            check("hresp", HRESP, e.resp);
            check("hrdata", HRDATA, e.rdata);
            check("waits", wcnt, e.waits);
            wcnt = 0;
        end
    end

    always @(negedge HCLK) begin : apb_mon
        apb_t p;
        if (|PSEL) begin
            if (apbq.size() == 0) check("apb_unexp", PSEL, 0);
            else begin
                p = apbq[0];
                check("psel", PSEL, p.sel);
                check("paddr", PADDR, p.addr);
                check("pwrite", PWRITE, p.wr);
                check("pstrb", PSTRB, p.strb);
                check("penable", PENABLE, aph);
                if (p.wr) check("pwdata", PWDATA, p.wdata);
                if (PENABLE && |(PSEL & PREADY)) begin
                    p = apbq.pop_front();
                    aph = 0;
                end else aph = 1;
            end
        end else if (aph) begin
            check("apb_drop", drop_ok, 1);
            if (apbq.size() > 0) p = apbq.pop_front();
            aph = 0;
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                        input int nw, input logic er);
        sb_t  e;
        apb_t p;
        logic hit;
        int   idx, n;
        wait_n  = nw;
        PSLVERR = er ? 4'hF : 4'h0;
        HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = 2'b10;
        hit = (a >= BASE) && (((a - BASE) >> 26) < 4);
        idx = int'((a - BASE) >> 26);
        n = 0;
        do begin @(negedge HCLK); n++; end while (!HREADYOUT && n < 50);
        if (!HREADYOUT) check("accept_to", HREADYOUT, 1);
        e.rdata = (!w && hit && !er && nw < 1000) ? PRDATA[idx*32 +: 32] : 32'h0;
        e.resp  = !hit || er || nw >= 1000;
        e.waits = !hit ? 1 : nw >= 1000 ? (w ? 2 : 1) + TOUT + 1 : (w ? 2 : 1) + nw + (er ? 2 : 0);
        sbq.push_back(e);
        if (hit) begin
            p.addr = a; p.sel = 4'(1 << idx); p.wr = w; p.wdata = wd; p.strb = strb_f(a, sz, w);
            apbq.push_back(p);
        end
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        HWDATA = wd;
    endtask

    task automatic drain();
        int n;
        HTRANS = 2'b00;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin @(negedge HCLK); n++; end
        if (sbq.size() != 0) check("drain_to", 64'(sbq.size()), 0);
        @(posedge HCLK); #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_psel"}, PSEL, 0);
        check({tag, "_penable"}, PENABLE, 0);
        check({tag, "_hreadyout"}, HREADYOUT, 1);
        check({tag, "_hresp"}, HRESP, 0);
        check({tag, "_paddr"}, PADDR, 0);
        check({tag, "_pwdata"}, PWDATA, 0);
        check({tag, "_pstrb"}, PSTRB, 0);
        check({tag, "_pwrite"}, PWRITE, 0);
        check({tag, "_hrdata"}, HRDATA, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, slv;
        logic [2:0] sz;
        logic [31:0] a;
        repeat (2) @(posedge HCLK);
        #1;
        chk_idle("rst");
        HRESET = 0;
        xfer(32'h8400_0010, 1, 2, 32'hDEAD_BEEF, 0, 0);
        drain();
        PRDATA[31:0] = 32'h1234_5678;
        xfer(32'h8000_0004, 0, 2, 0, 3, 0);
        drain();
        xfer(32'h8800_0003, 1, 0, 32'hAB00_0000, 0, 0);
        drain();
        xfer(32'h8800_0002, 1, 1, 32'hC0DE_0000, 1, 0);
        drain();
        xfer(32'h9000_0000, 0, 2, 0, 0, 0);
        drain();
        xfer(32'h7FFF_FFFC, 1, 2, 32'h1111_2222, 0, 0);
        drain();
        PRDATA[127:96] = 32'hCAFE_F00D;
        xfer(32'h8C00_0000, 0, 2, 0, 0, 1);
        drain();
        xfer(32'h8C00_0008, 1, 2, 32'h0BAD_0BAD, 2, 1);
        drain();
        PRDATA[63:32] = 32'hA5A5_5A5A;
        xfer(32'h8000_0020, 1, 2, 32'h0055_00AA, 0, 0);
        xfer(32'h8400_0008, 0, 2, 0, 0, 0);
        xfer(32'h8800_0004, 1, 2, 32'h7777_8888, 0, 0);
        drain();
        xfer(32'hA000_0000, 0, 2, 0, 0, 0);
        xfer(32'h8000_0040, 1, 2, 32'h4040_4040, 0, 0);
        drain();
        for (int i = 0; i < 12; i++) begin
            slv = $urandom_range(0, 3);
            sz  = 3'($urandom_range(0, 2));
            a   = BASE + (32'(slv) << 26) + (32'($urandom_range(0, 63)) << 2)
                  + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
            PRDATA[slv*32 +: 32] = $urandom();
            xfer(a, 1'($urandom_range(0, 1)), sz, $urandom(), $urandom_range(0, 2), $urandom_range(0, 5) == 0);
            drain();
        end
        drop_ok = 1;
        xfer(32'h8800_0000, 0, 2, 0, 1000, 0);
        n = 0;
        while (!PENABLE && n < 20) begin @(negedge HCLK); n++; end
        check("acc_reach", PENABLE, 1);
        @(posedge HCLK); #1;
        HRESET = 1;
        @(posedge HCLK); #1;
        chk_idle("midrst");
        HRESET = 0;
        @(negedge HCLK); #1;
        sbq.delete();
        apbq.delete();
        wait_n = 0;
        drop_ok = 0;
        @(posedge HCLK); #1;
        PRDATA[31:0] = 32'h0F0F_F0F0;
        xfer(32'h8000_0100, 0, 2, 0, 0, 0);
        drain();
`ifdef APB_TIMEOUT_EN
        drop_ok = 1;
        xfer(32'h8400_0000, 0, 2, 0, 1000, 0);
        drain();
        drop_ok = 0;
        wait_n = 0;
        xfer(32'h8400_0004, 1, 2, 32'h5151_5151, 0, 0);
        drain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
